// File: rtl/fp_mult_arbiter_if.sv
// rtl/fp_mult_arbiter_if.sv - requester, response and multiplier signals of fp_mult_arbiter
interface fp_mult_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_of;
  logic        rsp_uf;
  logic [31:0] mul_m;
  logic [31:0] mul_q;
  logic        mul_reset;
  logic [31:0] mul_out;
  logic        mul_of;
  logic        mul_uf;
  logic        busy;

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    input  rsp_ready, mul_out, mul_of, mul_uf,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_of, rsp_uf,
    output mul_m, mul_q, mul_reset, busy
  );

  // Environment side: requesters, consumer and the multiplier.
  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    output rsp_ready, mul_out, mul_of, mul_uf,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_of, rsp_uf,
    input  mul_m, mul_q, mul_reset, busy
  );
endinterface

// File: rtl/fp_mult_arbiter.sv
// rtl/fp_mult_arbiter.sv - two-port round-robin sequencer for a shared multi-cycle fp multiplier
module fp_mult_arbiter #(
  parameter int LOAD_CYCLES = 3,
  parameter int LATENCY     = 50,
  parameter int CNT_W       = 6
) (
  input  logic             clk,
  input  logic             reset,
  fp_mult_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(LATENCY - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;
  logic              id_q, id_d;
  logic [31:0]       m_q, m_d;
  logic [31:0]       q_q, q_d;
  logic [31:0]       data_q, data_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              of_q, of_d;
  logic              uf_q, uf_d;
  logic              grant;
  logic              accept0;
  logic              accept1;

  // Round-robin pick: a lone requester wins, contention goes to the one not served last.
  always_comb begin
    grant = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_grant_q;
    end
  end

  assign accept0 = (state_q == IDLE) && !grant && bus.req0_valid;
  assign accept1 = (state_q == IDLE) &&  grant && bus.req1_valid;

  // State and datapath registers; reset parks the multiplier and drops any in-flight result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      m_q          <= '0;
      q_q          <= '0;
      data_q       <= '0;
      rsp_valid_q  <= 1'b0;
      of_q         <= 1'b0;
      uf_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      m_q          <= m_d;
      q_q          <= q_d;
      data_q       <= data_d;
      rsp_valid_q  <= rsp_valid_d;
      of_q         <= of_d;
      uf_q         <= uf_d;
    end
  end

  // Next-state: accept -> hold operands under reset -> compute -> present result until taken.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    m_d          = m_q;
    q_d          = q_q;
    data_d       = data_q;
    rsp_valid_d  = rsp_valid_q;
    of_d         = of_q;
    uf_d         = uf_q;
    case (state_q)
      IDLE: begin
        if (accept0 || accept1) begin
          m_d     = grant ? bus.req1_a : bus.req0_a;
          q_d     = grant ? bus.req1_b : bus.req0_b;
          id_d    = grant;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (cnt_q == LOAD_LAST) begin
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (cnt_q == RUN_LAST) begin
          data_d      = bus.mul_out;
          of_d        = bus.mul_of;
          uf_d        = bus.mul_uf;
          rsp_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          rsp_valid_d  = 1'b0;
          last_grant_d = id_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req0_ready = accept0;
  assign bus.req1_ready = accept1;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_data   = data_q;
  assign bus.rsp_of     = of_q;
  assign bus.rsp_uf     = uf_q;
  assign bus.mul_m      = m_q;
  assign bus.mul_q      = q_q;
  assign bus.mul_reset  = (state_q != RUN);
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// tb/tb_fp_mult_arbiter.sv - randomized self-checking bench for fp_mult_arbiter
module tb_fp_mult_arbiter;
  localparam int LOAD_CYCLES = 3;
  localparam int LATENCY     = 50;
  localparam int CNT_W       = 6;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  fp_mult_arbiter_if bus ();

  fp_mult_arbiter #(.LOAD_CYCLES(LOAD_CYCLES), .LATENCY(LATENCY), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int model_last = 1;          // requester served last; 1 after reset so requester 0 wins first
  logic [34:0] exp_q[$];       // {id, of, uf, product} in issue order

  // Stand-in multiplier result: known spec vectors, otherwise a scrambled deterministic value.
  function automatic logic [33:0] fake_mul(input logic [31:0] a, input logic [31:0] b);
    logic [8:0]  es;
    logic [33:0] r;
    es = {1'b0, a[30:23]} + {1'b0, b[30:23]};
    if (a == 32'h49072340 && b == 32'h44520000)      r = {2'b00, 32'h4DDDB5D5};
    else if (a == 32'hC3818000 && b == 32'h49072340) r = {2'b00, 32'hCD08B8A9};
    else if (a == 32'h7F7FFFF0 && b == 32'h41A00000) r = {2'b10, 32'h7F800000};
    else if (a[30:0] == 31'd0 || b[30:0] == 31'd0)   r = {2'b00, 32'h0};
    else if (a == 32'h3F800000)                      r = {2'b00, b};
    else r = {es > 9'd381, es < 9'd127, (a ^ {b[15:0], b[31:16]}) + 32'h9E3779B9};
    return r;
  endfunction

  // Multiplier model: result valid only in the LATENCY-th cycle after reset release,
  // and only if operands were held through the load phase and stay put while computing.
  int          mcnt = 0;
  int          hcnt = 0;
  logic [31:0] lm, lq;
  logic [33:0] mres;
  logic        mgood;
  always @(posedge clk) begin
    if (bus.mul_reset) begin
      mcnt <= 0;
      if (bus.mul_m == lm && bus.mul_q == lq) begin
        if (hcnt < 1000) hcnt <= hcnt + 1;
      end else begin
        hcnt <= 0;
      end
      lm <= bus.mul_m;
      lq <= bus.mul_q;
    end else if (mcnt < 1000) begin
      mcnt <= mcnt + 1;
    end
  end
  assign mres  = fake_mul(bus.mul_m, bus.mul_q);
  assign mgood = !bus.mul_reset && (mcnt == LATENCY - 1) && (hcnt >= LOAD_CYCLES - 1)
                 && (bus.mul_m == lm) && (bus.mul_q == lq);
  assign bus.mul_out = mgood ? mres[31:0] : 32'hBAD0BAD0;
  assign bus.mul_of  = mgood ? mres[33] : 1'b1;
  assign bus.mul_uf  = mgood ? mres[32] : 1'b1;

  // Scoreboard feed: every accepted pair, recorded before its accept edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.req0_valid && bus.req0_ready) exp_q.push_back({1'b0, fake_mul(bus.req0_a, bus.req0_b)});
      if (bus.req1_valid && bus.req1_ready) exp_q.push_back({1'b1, fake_mul(bus.req1_a, bus.req1_b)});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    model_last = 1;
    exp_q.delete();
  endtask

  task automatic wait_accept(output int id, output int nready, output bit to);
    to = 1'b1; id = -1; nready = 0;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (bus.req0_ready || bus.req1_ready) begin
        id = bus.req1_ready ? 1 : 0;
        nready = int'(bus.req0_ready) + int'(bus.req1_ready);
        to = 1'b0;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic finish_op(output logic [34:0] got, output bit to);
    to = 1'b1; got = '0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (bus.rsp_valid) begin
        got = {bus.rsp_id, bus.rsp_of, bus.rsp_uf, bus.rsp_data};
        to = 1'b0;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!to) begin
      step();
      model_last = int'(got[34]);
    end
  endtask

  function automatic logic [34:0] pop_exp();
    if (exp_q.size() == 0) return '1;
    return exp_q.pop_front();
  endfunction

  // Single requester on port who: issue, wait for accept, release valid, collect response.
  task automatic do_op(input int who, input logic [31:0] a, input logic [31:0] b,
                       output logic [34:0] got, output int id, output bit to);
    int n;
    bit ato;
    if (who == 0) begin bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1; end
    else          begin bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1; end
    wait_accept(id, n, ato);
    step();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    got = '0;
    to = ato;
    if (!ato) finish_op(got, to);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    tests++;
    if ({bus.busy, bus.mul_reset, bus.rsp_valid, bus.rsp_id, bus.rsp_of, bus.rsp_uf} !== 6'b010000) begin
      fails++;
      $display("FAIL reset_ctrl got busy/mulrst/rv/id/of/uf=%b want 010000",
               {bus.busy, bus.mul_reset, bus.rsp_valid, bus.rsp_id, bus.rsp_of, bus.rsp_uf});
    end
    tests++;
    if ({bus.rsp_data, bus.mul_m, bus.mul_q} !== 96'h0) begin
      fails++;
      $display("FAIL reset_data got data=%h m=%h q=%h want 0", bus.rsp_data, bus.mul_m, bus.mul_q);
    end
    rst = 1'b0;
    step();
    tests++;
    if ({bus.req0_ready, bus.req1_ready, bus.busy} !== 3'b000) begin
      fails++;
      $display("FAIL reset_idle got r0/r1/busy=%b want 000", {bus.req0_ready, bus.req1_ready, bus.busy});
    end
    model_last = 1;
    exp_q.delete();
  endtask

  task automatic test_single();
    int id, n, edge_no, hi, lo;
    bit to;
    logic [34:0] got, exp;
    bus.rsp_ready = 1'b1;
    bus.req0_a = 32'h49072340; bus.req0_b = 32'h44520000; bus.req0_valid = 1'b1;
    wait_accept(id, n, to);
    tests++;
    if (to || id != 0 || n != 1) begin
      fails++;
      $display("FAIL single_accept got to=%0d id=%0d nready=%0d want 0 0 1", to, id, n);
    end
    step();
    bus.req0_valid = 1'b0;
    tests++;
    if (bus.req0_ready !== 1'b0 || bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL single_ready_pulse got ready=%b busy=%b want 0 1", bus.req0_ready, bus.busy);
    end
    // Accept edge is edge 1.
    edge_no = 1; hi = 0; lo = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.rsp_valid) break;
      if (bus.mul_reset) hi++; else lo++;
      step();
      edge_no++;
    end
    tests++;
    if (bus.rsp_valid !== 1'b1 || edge_no != LOAD_CYCLES + LATENCY + 1) begin
      fails++;
      $display("FAIL single_latency got valid=%b edges=%0d want 1 %0d", bus.rsp_valid, edge_no,
               LOAD_CYCLES + LATENCY + 1);
    end
    tests++;
    if (hi != LOAD_CYCLES || lo != LATENCY) begin
      fails++;
      $display("FAIL single_mulreset got high=%0d low=%0d want %0d %0d", hi, lo, LOAD_CYCLES, LATENCY);
    end
    finish_op(got, to);
    exp = pop_exp();
    tests++;
    if (to || got !== {1'b0, 2'b00, 32'h4DDDB5D5} || got !== exp) begin
      fails++;
      $display("FAIL single_result got %h want %h", got, {1'b0, 2'b00, 32'h4DDDB5D5});
    end
    tests++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL single_return got valid=%b busy=%b want 0 0", bus.rsp_valid, bus.busy);
    end
  endtask

  task automatic test_contention();
    int id, n, want_id;
    bit to;
    logic [34:0] got, exp;
    bus.req0_a = 32'h49072340; bus.req0_b = 32'h44520000; bus.req0_valid = 1'b1;
    bus.req1_a = 32'hC3818000; bus.req1_b = 32'h49072340; bus.req1_valid = 1'b1;
    do_reset();
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      want_id = 1 - model_last;
      wait_accept(id, n, to);
      tests++;
      if (to || id != want_id || n != 1 || id != (k % 2)) begin
        fails++;
        $display("FAIL contention_grant%0d got id=%0d nready=%0d want %0d 1", k, id, n, want_id);
      end
      step();
      finish_op(got, to);
      exp = pop_exp();
      tests++;
      if (to || got !== exp) begin
        fails++;
        $display("FAIL contention_result%0d got %h want %h", k, got, exp);
      end
      if (k == 1) begin
        tests++;
        if (got !== {1'b1, 2'b00, 32'hCD08B8A9}) begin
          fails++;
          $display("FAIL contention_req1 got %h want %h", got, {1'b1, 2'b00, 32'hCD08B8A9});
        end
      end
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    step();
    step();
  endtask

  task automatic test_back_to_back_backpressure();
    int id, n, bad;
    bit to;
    logic [34:0] snap, exp;
    bus.rsp_ready = 1'b0;
    bus.req0_a = $urandom; bus.req0_b = $urandom; bus.req0_valid = 1'b1;
    bus.req1_a = $urandom; bus.req1_b = $urandom; bus.req1_valid = 1'b1;
    wait_accept(id, n, to);
    step();
    to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (bus.rsp_valid) begin to = 1'b0; break; end
      step();
    end
    tests++;
    if (to) begin
      fails++;
      $display("FAIL bp_wait got rsp_valid=%b want 1", bus.rsp_valid);
    end
    snap = {bus.rsp_id, bus.rsp_of, bus.rsp_uf, bus.rsp_data};
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if ({bus.rsp_id, bus.rsp_of, bus.rsp_uf, bus.rsp_data} !== snap || bus.rsp_valid !== 1'b1
          || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 || bus.busy !== 1'b1) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL bp_hold got %0d unstable cycles want 0", bad);
    end
    exp = pop_exp();
    tests++;
    if (snap !== exp) begin
      fails++;
      $display("FAIL bp_result got %h want %h", snap, exp);
    end
    bus.rsp_ready = 1'b1;
    step();
    tests++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL bp_release got valid=%b busy=%b want 0 0", bus.rsp_valid, bus.busy);
    end
    model_last = int'(snap[34]);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    step();
  endtask

  task automatic test_overflow_zero();
    logic [31:0] va[3], vb[3];
    logic [34:0] want[3];
    logic [34:0] got, exp;
    int id;
    bit to;
    va[0] = 32'h7F7FFFF0; vb[0] = 32'h41A00000; want[0] = {1'b0, 2'b10, 32'h7F800000};
    va[1] = 32'h00000000; vb[1] = 32'h4EA0C8E4; want[1] = {1'b0, 2'b00, 32'h00000000};
    va[2] = 32'h3F800000; vb[2] = 32'h4EA0C8E4; want[2] = {1'b0, 2'b00, 32'h4EA0C8E4};
    for (int k = 0; k < 3; k++) begin
      do_op(0, va[k], vb[k], got, id, to);
      exp = pop_exp();
      tests++;
      if (to || got !== want[k] || got !== exp) begin
        fails++;
        $display("FAIL special%0d got %h want %h", k, got, want[k]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int id, n, seen;
    bit to;
    logic [34:0] got, exp;
    bus.rsp_ready = 1'b1;
    bus.req1_a = $urandom; bus.req1_b = $urandom; bus.req1_valid = 1'b1;
    wait_accept(id, n, to);
    step();
    bus.req1_valid = 1'b0;
    for (int i = 0; i < 20 && bus.mul_reset; i++) step();
    for (int i = 0; i < 10; i++) step();
    @(posedge clk);
    #5;
    rst = 1'b1;
    #1;
    tests++;
    if ({bus.mul_reset, bus.busy, bus.rsp_valid, bus.mul_m} !== {3'b100, 32'h0}) begin
      fails++;
      $display("FAIL midrun_reset got mulrst/busy/valid=%b m=%h want 100 0",
               {bus.mul_reset, bus.busy, bus.rsp_valid}, bus.mul_m);
    end
    step();
    rst = 1'b0;
    model_last = 1;
    exp_q.delete();
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (bus.rsp_valid || bus.busy) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL midrun_discard got %0d active cycles want 0", seen);
    end
    do_op(0, 32'h49072340, 32'h44520000, got, id, to);
    exp = pop_exp();
    tests++;
    if (to || got !== exp || got !== {1'b0, 2'b00, 32'h4DDDB5D5}) begin
      fails++;
      $display("FAIL midrun_next got %h want %h", got, exp);
    end
  endtask

  task automatic test_operand_stability();
    int id, n, bad;
    bit to;
    logic [31:0] a, b;
    logic [34:0] got, exp;
    a = $urandom; b = $urandom;
    bus.rsp_ready = 1'b1;
    bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
    wait_accept(id, n, to);
    step();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.rsp_valid) break;
      bus.req1_a = $urandom; bus.req1_b = $urandom;
      bus.req0_a = $urandom; bus.req0_b = $urandom;
      #1;
      if (bus.mul_m !== a || bus.mul_q !== b || bus.req1_ready !== 1'b0) bad++;
      step();
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL stable_operands got %0d bad cycles want 0", bad);
    end
    finish_op(got, to);
    exp = pop_exp();
    tests++;
    if (to || got !== exp || got[31:0] !== fake_mul(a, b)) begin
      fails++;
      $display("FAIL stable_result got %h want %h", got, exp);
    end
    wait_accept(id, n, to);
    tests++;
    if (to || id != 1) begin
      fails++;
      $display("FAIL stable_next_grant got id=%0d want 1", id);
    end
    step();
    bus.req1_valid = 1'b0;
    finish_op(got, to);
    exp = pop_exp();
    tests++;
    if (to || got !== exp) begin
      fails++;
      $display("FAIL stable_req1 got %h want %h", got, exp);
    end
  endtask

  task automatic test_random();
    int id, n, want_id;
    bit to;
    logic [1:0] v;
    logic [34:0] got, exp;
    for (int k = 0; k < 8; k++) begin
      v = 2'($urandom_range(1, 3));
      bus.req0_a = $urandom; bus.req0_b = $urandom;
      bus.req1_a = $urandom; bus.req1_b = $urandom;
      bus.req0_valid = v[0];
      bus.req1_valid = v[1];
      want_id = (v == 2'b11) ? 1 - model_last : (v[1] ? 1 : 0);
      wait_accept(id, n, to);
      tests++;
      if (to || id != want_id || n != 1) begin
        fails++;
        $display("FAIL rand_grant%0d got id=%0d nready=%0d want %0d 1", k, id, n, want_id);
      end
      step();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      to = 1'b1;
      got = '0;
      for (int i = 0; i < 600; i++) begin
        bus.rsp_ready = 1'($urandom % 2);
        #1;
        if (bus.rsp_valid && bus.rsp_ready) begin
          got = {bus.rsp_id, bus.rsp_of, bus.rsp_uf, bus.rsp_data};
          to = 1'b0;
          step();
          break;
        end
        step();
      end
      if (!to) model_last = int'(got[34]);
      exp = pop_exp();
      tests++;
      if (to || got !== exp) begin
        fails++;
        $display("FAIL rand_result%0d got %h want %h", k, got, exp);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_back_to_back_backpressure();
    test_overflow_zero();
    test_reset_mid_run();
    test_operand_stability();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
